// File: rtl/mac_acc_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mac_acc_pipe
//  Description : Two-stage pipelined multiply-accumulate unit with valid
//                handshake, synchronous clear, signed/unsigned operand mode,
//                saturating or wrapping accumulation, sticky overflow flag
//                and a saturating sample counter.
//
//  Ports
//    clk        in   1       rising-edge clock
//    rst        in   1       asynchronous active-low reset
//    in_valid   in   1       a/b carry a sample this cycle
//    a          in   DATA_W  multiplicand
//    b          in   DATA_W  multiplier
//    clear      in   1       start a new accumulation (ordered with samples)
//    y          out  ACC_W   accumulator value
//    out_valid  out  1       y was updated by a valid sample this cycle
//    overflow   out  1       sticky overflow/underflow since last clear
//    count      out  CNT_W   samples accumulated since last clear
//
//  Timing: a sample presented in cycle N appears in y in cycle N+2.
//
//  Revision    : 1.0  initial release
// ============================================================================
module mac_acc_pipe #(
    parameter int DATA_W   = 4,
    parameter int ACC_W    = 10,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              clear,
    output logic [ACC_W-1:0]  y,
    output logic              out_valid,
    output logic              overflow,
    output logic [CNT_W-1:0]  count
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ACC_W + 1;
    localparam int EXT_W  = SUM_W - PROD_W;   // >= 1 because ACC_W >= 2*DATA_W

    // Rails used when clamping. In unsigned mode the positive rail is all
    // ones; the negative rail is only ever selected in signed mode.
    localparam logic [ACC_W-1:0] c_pos_rail = (SIGNED != 0) ?
                                              {1'b0, {(ACC_W-1){1'b1}}} :
                                              {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] c_neg_rail = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Stage 1: multiply
    // ------------------------------------------------------------------
    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_prod;

    // Extending both operands to the product width and keeping the low
    // PROD_W bits of the product gives the exact two's-complement product
    // in signed mode and the exact unsigned product otherwise.
    generate
        if (SIGNED != 0) begin : g_signed_mul
            assign w_a_ext = {{DATA_W{a[DATA_W-1]}}, a};
            assign w_b_ext = {{DATA_W{b[DATA_W-1]}}, b};
        end else begin : g_unsigned_mul
            assign w_a_ext = {{DATA_W{1'b0}}, a};
            assign w_b_ext = {{DATA_W{1'b0}}, b};
        end
    endgenerate

    assign w_prod = w_a_ext * w_b_ext;

    logic [PROD_W-1:0] p1_q;
    logic              v1_q;
    logic              c1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_q <= '0;
            v1_q <= 1'b0;
            c1_q <= 1'b0;
        end else begin
            p1_q <= w_prod;
            v1_q <= in_valid;
            c1_q <= clear;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulate
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] y_q,  y_d;
    logic             ov_q, ov_d;
    logic             vo_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SUM_W-1:0] w_p_ext;
    logic [SUM_W-1:0] w_base;
    logic [SUM_W-1:0] w_sum;
    logic             w_ovf_hi;
    logic             w_ovf_lo;
    logic             w_ovf;

    // One guard bit above the accumulator captures the carry (unsigned) or
    // the true sign (signed) of the addition.
    generate
        if (SIGNED != 0) begin : g_signed_ext
            assign w_p_ext = {{EXT_W{p1_q[PROD_W-1]}}, p1_q};
            assign w_base  = c1_q ? '0 : {y_q[ACC_W-1], y_q};
        end else begin : g_unsigned_ext
            assign w_p_ext = {{EXT_W{1'b0}}, p1_q};
            assign w_base  = c1_q ? '0 : {1'b0, y_q};
        end
    endgenerate

    assign w_sum = w_base + (v1_q ? w_p_ext : '0);

    // Signed: the guard bit disagreeing with the accumulator MSB means the
    // result left the representable range; the guard bit gives direction.
    generate
        if (SIGNED != 0) begin : g_signed_ovf
            assign w_ovf_hi = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
            assign w_ovf_lo =  w_sum[ACC_W] & ~w_sum[ACC_W-1];
        end else begin : g_unsigned_ovf
            assign w_ovf_hi = w_sum[ACC_W];
            assign w_ovf_lo = 1'b0;
        end
    endgenerate

    assign w_ovf = w_ovf_hi | w_ovf_lo;

    generate
        if (SATURATE != 0) begin : g_sat
            always_comb begin
                y_d = w_sum[ACC_W-1:0];
                if (w_ovf_hi) begin
                    y_d = c_pos_rail;
                end else if (w_ovf_lo) begin
                    y_d = c_neg_rail;
                end
            end
        end else begin : g_wrap
            always_comb begin
                y_d = w_sum[ACC_W-1:0];
            end
        end
    endgenerate

    // A clear restarts the flag, but an overflow caused by a sample issued
    // together with that clear is still reported.
    assign ov_d = (c1_q ? 1'b0 : ov_q) | (v1_q & w_ovf);

    // Counter sticks at its maximum instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (c1_q) begin
            cnt_d = CNT_W'(v1_q);
        end else if (v1_q && (cnt_q != c_cnt_max)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_q   <= '0;
            ov_q  <= 1'b0;
            vo_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            y_q   <= y_d;
            ov_q  <= ov_d;
            vo_q  <= v1_q;
            cnt_q <= cnt_d;
        end
    end

    assign y         = y_q;
    assign out_valid = vo_q;
    assign overflow  = ov_q;
    assign count     = cnt_q;

endmodule
`default_nettype wire
